// File: rtl/serial_add_ctrl_pkg.sv
// Shared encodings and defaults for the bit-serial adder controller.
package serial_add_ctrl_pkg;

  localparam int unsigned SA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    SA_IDLE  = 2'd0,
    SA_SHIFT = 2'd1,
    SA_DONE  = 2'd2
  } sa_state_e;

endpackage

// File: rtl/half_adder.sv
// Single-bit half adder, the basic datapath primitive.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

// File: rtl/serial_add_ctrl_full_adder_cell.sv
// Combinational full adder built from two half adders and an OR of their carries.
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (
    .x (x),
    .y (y),
    .s (s0),
    .c (c0)
  );

  half_adder u_ha1 (
    .x (s0),
    .y (ci),
    .s (s),
    .c (c1)
  );

  assign co = c0 | c1;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared full-adder cell processes the operands LSB first,
// one bit per clock, with a start/ready request and a one-cycle done pulse.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = SA_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  sa_state_e        state;
  sa_state_e        state_nxt;
  logic             accept_c;
  logic             shift_c;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CNT_W-1:0] bitcnt;
  logic             cell_s;
  logic             cell_co;

  full_adder_cell u_cell (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .ci (carry),
    .s  (cell_s),
    .co (cell_co)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SA_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath strobes
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    shift_c   = 1'b0;
    case (state)
      SA_IDLE: begin
        if (start) begin
          accept_c  = 1'b1;
          state_nxt = SA_SHIFT;
        end
      end
      SA_SHIFT: begin
        shift_c = 1'b1;
        if (bitcnt == LAST_BIT) begin
          state_nxt = SA_DONE;
        end
      end
      SA_DONE: begin
        state_nxt = SA_IDLE;
      end
      default: begin
        state_nxt = SA_IDLE;
      end
    endcase
  end

  // Operand/result shifters; ready and done are flopped from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      ready  <= 1'b1;
      done   <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      carry  <= 1'b0;
      bitcnt <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      ready <= (state_nxt == SA_IDLE);
      done  <= (state_nxt == SA_DONE);
      if (accept_c) begin
        a_sh   <= a;
        b_sh   <= b;
        carry  <= cin;
        bitcnt <= '0;
        sum    <= '0;
        cout   <= 1'b0;
      end else if (shift_c) begin
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        carry <= cell_co;
        sum   <= {cell_s, sum[WIDTH-1:1]};
        // Counter parks at zero after the last bit so it never passes WIDTH-1
        if (bitcnt == LAST_BIT) begin
          cout   <= cell_co;
          bitcnt <= '0;
        end else begin
          bitcnt <= bitcnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH 8, 2 and 16 against an arithmetic model.
module tb_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cin;
  logic [15:0] a_bus;
  logic [15:0] b_bus;
  int          sel;

  logic        start8, start2, start16;
  logic        ready8, ready2, ready16;
  logic        done8, done2, done16;
  logic [7:0]  sum8;
  logic [1:0]  sum2;
  logic [15:0] sum16;
  logic        cout8, cout2, cout16;

  int n_pass  = 0;
  int n_total = 0;

  assign start8  = start && (sel == 0);
  assign start2  = start && (sel == 1);
  assign start16 = start && (sel == 2);

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk (clk), .rst (rst), .start (start8), .a (a_bus[7:0]), .b (b_bus[7:0]), .cin (cin),
    .ready (ready8), .done (done8), .sum (sum8), .cout (cout8)
  );

  serial_add_ctrl #(.WIDTH(2)) u_dut2 (
    .clk (clk), .rst (rst), .start (start2), .a (a_bus[1:0]), .b (b_bus[1:0]), .cin (cin),
    .ready (ready2), .done (done2), .sum (sum2), .cout (cout2)
  );

  serial_add_ctrl #(.WIDTH(16)) u_dut16 (
    .clk (clk), .rst (rst), .start (start16), .a (a_bus), .b (b_bus), .cin (cin),
    .ready (ready16), .done (done16), .sum (sum16), .cout (cout16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int wid();
    case (sel)
      1:       return 2;
      2:       return 16;
      default: return 8;
    endcase
  endfunction

  function automatic logic rdy();
    case (sel)
      1:       return ready2;
      2:       return ready16;
      default: return ready8;
    endcase
  endfunction

  function automatic logic dn();
    case (sel)
      1:       return done2;
      2:       return done16;
      default: return done8;
    endcase
  endfunction

  function automatic logic [16:0] res();
    case (sel)
      1:       return {14'd0, cout2, sum2};
      2:       return {cout16, sum16};
      default: return {8'd0, cout8, sum8};
    endcase
  endfunction

  // Reference: plain integer sum of the width-truncated operands, kept to WIDTH+1 bits
  function automatic logic [16:0] model(input int w, input logic [15:0] x, input logic [15:0] y,
                                        input logic c);
    int unsigned m;
    int unsigned t;
    m = (32'd1 << w) - 32'd1;
    t = (int'(x) & m) + (int'(y) & m) + int'(c);
    return 17'(t & ((m << 1) | 32'd1));
  endfunction

  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic c,
                        output logic [16:0] r, output int lat);
    int guard;
    guard = 0;
    while (!rdy() && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) check("ready_timeout", 32'(rdy()), 32'd1);
    a_bus = x;
    b_bus = y;
    cin   = c;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (!dn() && lat < 100) begin
      tick();
      lat++;
    end
    if (lat >= 100) check("done_timeout", 32'(dn()), 32'd1);
    r = res();
  endtask

  initial begin
    logic [16:0] r;
    logic [16:0] exp_r;
    logic [15:0] x, y;
    logic        c;
    int          lat;
    int          dones;
    int          last_acc;
    logic        was_rdy;
    logic [16:0] expq[$];

    rst = 1'b1; start = 1'b0; cin = 1'b0; a_bus = '0; b_bus = '0; sel = 0;
    tick();
    tick();
    check("rst_ready", 32'(ready8), 32'd1);
    check("rst_done",  32'(done8),  32'd0);
    check("rst_sum",   32'(sum8),   32'd0);
    check("rst_cout",  32'(cout8),  32'd0);
    rst = 1'b0;
    tick();

    // Directed corner cases at WIDTH=8
    run_op(16'h00FF, 16'h0001, 1'b0, r, lat);
    check("ff_plus_1", 32'(r), 32'h100);
    check("ff_latency", 32'(lat), 32'd9);
    tick();
    check("ff_ready_after", 32'(ready8), 32'd1);
    check("ff_done_after",  32'(done8),  32'd0);

    run_op(16'h0000, 16'h0000, 1'b1, r, lat);
    check("zero_cin", 32'(r), 32'h001);
    run_op(16'h00A5, 16'h005A, 1'b1, r, lat);
    check("a5_5a_cin", 32'(r), 32'h100);

    // start pulses during SHIFT and DONE must be ignored
    tick();
    exp_r = model(8, 16'h0033, 16'h0044, 1'b1);
    a_bus = 16'h0033; b_bus = 16'h0044; cin = 1'b1; start = 1'b1;
    tick();
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      start = (k == 3) || done8;
      if (start) begin
        a_bus = 16'($urandom); b_bus = 16'($urandom); cin = 1'($urandom);
      end
      if (done8) begin
        dones++;
        check("ignore_result", 32'(res()), 32'(exp_r));
      end
      tick();
    end
    start = 1'b0;
    check("ignore_one_done", 32'(dones), 32'd1);
    check("ignore_idle", 32'(ready8), 32'd1);

    // Reset on the 4th SHIFT edge aborts without a done pulse
    a_bus = 16'h00F0; b_bus = 16'h000F; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_ready", 32'(ready8), 32'd1);
    check("abort_result", 32'(res()), 32'd0);
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      if (done8) dones++;
      tick();
    end
    check("abort_no_done", 32'(dones), 32'd0);
    x = 16'($urandom); y = 16'($urandom); c = 1'($urandom);
    run_op(x, y, c, r, lat);
    check("after_abort", 32'(r), 32'(model(8, x, y, c)));
    tick();

    // Reset and start together: reset wins
    rst = 1'b1; start = 1'b1; a_bus = 16'h0011; b_bus = 16'h0022;
    tick();
    check("rst_start_ready", 32'(ready8), 32'd1);
    rst = 1'b0; start = 1'b0;
    tick();
    check("rst_start_idle", 32'(ready8), 32'd1);

    // Continuous start: back-to-back accepts every WIDTH+2 cycles
    last_acc = -1;
    a_bus = 16'($urandom); b_bus = 16'($urandom); cin = 1'($urandom);
    start = 1'b1;
    for (int cyc = 0; cyc < 65; cyc++) begin
      was_rdy = ready8;
      if (was_rdy) begin
        expq.push_back(model(8, a_bus, b_bus, cin));
        if (last_acc >= 0) check("stream_spacing", 32'(cyc - last_acc), 32'd10);
        last_acc = cyc;
      end
      if (done8) begin
        if (expq.size() == 0) check("stream_spurious_done", 32'd1, 32'd0);
        else check("stream_result", 32'(res()), 32'(expq.pop_front()));
      end
      tick();
      if (was_rdy) begin
        a_bus = 16'($urandom); b_bus = 16'($urandom); cin = 1'($urandom);
      end
    end
    start = 1'b0;

    // Random operands at the extreme widths
    for (int s = 1; s <= 2; s++) begin
      sel = s;
      for (int n = 0; n < 200; n++) begin
        x = 16'($urandom); y = 16'($urandom); c = 1'($urandom);
        run_op(x, y, c, r, lat);
        check(s == 1 ? "rand_w2_sum" : "rand_w16_sum", 32'(r), 32'(model(wid(), x, y, c)));
        check(s == 1 ? "rand_w2_lat" : "rand_w16_lat", 32'(lat), 32'(wid() + 1));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
